// File: rtl/vga_scan_controller.sv
// Raster scan timing generator: pixel divider, X/Y position counters, line/frame
// strobes, a frame counter and a GameTick pulse every TICK_FRAMES frames.
module vga_scan_controller #(
    parameter int DIV         = 2,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int TICK_FRAMES = 1
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Run,
    output logic [15:0] XAxis,
    output logic [15:0] YAxis,
    output logic        PixelTick,
    output logic        LineEnd,
    output logic        FrameStart,
    output logic        GameTick,
    output logic [15:0] FrameCount
);

    localparam logic [3:0]  DIV_LAST  = 4'(DIV - 1);
    localparam logic [15:0] H_LAST    = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST    = 16'(V_TOTAL - 1);
    localparam logic [15:0] TICK_LAST = 16'(TICK_FRAMES - 1);

    logic [3:0]  div_r;
    logic [15:0] x_r;
    logic [15:0] y_r;
    logic [15:0] tick_cnt_r;
    logic [15:0] frame_count_r;
    logic        line_end_r;
    logic        frame_start_r;
    logic        game_tick_r;

    logic        pixel_tick_s;
    logic        x_last_s;
    logic        y_last_s;
    logic        tick_last_s;
    logic        line_wrap_s;
    logic        frame_wrap_s;
    logic [3:0]  div_next_s;
    logic [15:0] x_next_s;
    logic [15:0] y_next_s;
    logic [15:0] tick_next_s;

    // Next-state decode; ">=" keeps the counters in range even if a bad value appears.
    always_comb begin
        pixel_tick_s = 1'b0;
        x_last_s     = (x_r >= H_LAST);
        y_last_s     = (y_r >= V_LAST);
        tick_last_s  = (tick_cnt_r >= TICK_LAST);
        div_next_s   = div_r;
        x_next_s     = x_r;
        y_next_s     = y_r;
        tick_next_s  = tick_cnt_r;

        if (Run && !Reset && (div_r == DIV_LAST)) begin
            pixel_tick_s = 1'b1;
        end else begin
            pixel_tick_s = 1'b0;
        end

        if (Run) begin
            if (div_r >= DIV_LAST) begin
                div_next_s = 4'd0;
            end else begin
                div_next_s = div_r + 4'd1;
            end
        end else begin
            div_next_s = div_r;
        end

        line_wrap_s  = pixel_tick_s && x_last_s;
        frame_wrap_s = line_wrap_s && y_last_s;

        if (pixel_tick_s) begin
            if (x_last_s) begin
                x_next_s = 16'd0;
            end else begin
                x_next_s = x_r + 16'd1;
            end
        end else begin
            x_next_s = x_r;
        end

        if (line_wrap_s) begin
            if (y_last_s) begin
                y_next_s = 16'd0;
            end else begin
                y_next_s = y_r + 16'd1;
            end
        end else begin
            y_next_s = y_r;
        end

        if (frame_wrap_s) begin
            if (tick_last_s) begin
                tick_next_s = 16'd0;
            end else begin
                tick_next_s = tick_cnt_r + 16'd1;
            end
        end else begin
            tick_next_s = tick_cnt_r;
        end
    end

    // Divider and scan position.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            div_r <= 4'd0;
            x_r   <= 16'd0;
            y_r   <= 16'd0;
        end else begin
            div_r <= div_next_s;
            x_r   <= x_next_s;
            y_r   <= y_next_s;
        end
    end

    // Strobes are set on the wrapping edge so they coincide with the new (0,*) position.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            line_end_r    <= 1'b0;
            frame_start_r <= 1'b0;
            game_tick_r   <= 1'b0;
            tick_cnt_r    <= 16'd0;
        end else begin
            line_end_r    <= line_wrap_s;
            frame_start_r <= frame_wrap_s;
            game_tick_r   <= frame_wrap_s && tick_last_s;
            tick_cnt_r    <= tick_next_s;
        end
    end

    // FrameCount lags FrameStart by one cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            frame_count_r <= 16'd0;
        end else if (frame_start_r) begin
            frame_count_r <= frame_count_r + 16'd1;
        end else begin
            frame_count_r <= frame_count_r;
        end
    end

    assign PixelTick  = pixel_tick_s;
    assign XAxis      = x_r;
    assign YAxis      = y_r;
    assign LineEnd    = line_end_r;
    assign FrameStart = frame_start_r;
    assign GameTick   = game_tick_r;
    assign FrameCount = frame_count_r;

endmodule

// File: tb/tb_vga_scan_controller.sv
// Checks four scan controller configurations against hand-computed checkpoints,
// then exercises Run freeze and mid-frame Reset on the small DIV=2 instance.
module tb_vga_scan_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst1, run1, run_all;
    logic [3:0][15:0] xa, ya, fca;
    logic [3:0] pta, lea, fsa, gta;

    vga_scan_controller #(.DIV(2), .H_TOTAL(8), .V_TOTAL(4), .TICK_FRAMES(1)) u1 (
        .Clock(clk), .Reset(rst1), .Run(run1), .XAxis(xa[0]), .YAxis(ya[0]),
        .PixelTick(pta[0]), .LineEnd(lea[0]), .FrameStart(fsa[0]), .GameTick(gta[0]),
        .FrameCount(fca[0]));
    vga_scan_controller #(.DIV(1), .H_TOTAL(8), .V_TOTAL(4), .TICK_FRAMES(1)) u2 (
        .Clock(clk), .Reset(rst), .Run(run_all), .XAxis(xa[1]), .YAxis(ya[1]),
        .PixelTick(pta[1]), .LineEnd(lea[1]), .FrameStart(fsa[1]), .GameTick(gta[1]),
        .FrameCount(fca[1]));
    vga_scan_controller #(.DIV(2), .H_TOTAL(8), .V_TOTAL(4), .TICK_FRAMES(3)) u3 (
        .Clock(clk), .Reset(rst), .Run(run_all), .XAxis(xa[2]), .YAxis(ya[2]),
        .PixelTick(pta[2]), .LineEnd(lea[2]), .FrameStart(fsa[2]), .GameTick(gta[2]),
        .FrameCount(fca[2]));
    vga_scan_controller u4 (
        .Clock(clk), .Reset(rst), .Run(run_all), .XAxis(xa[3]), .YAxis(ya[3]),
        .PixelTick(pta[3]), .LineEnd(lea[3]), .FrameStart(fsa[3]), .GameTick(gta[3]),
        .FrameCount(fca[3]));

    typedef struct {
        int   dut;
        int   cyc;
        int   x;
        int   y;
        logic pt;
        logic le;
        logic fs;
        logic gt;
        int   fc;
    } vec_t;

    vec_t tbl[$];
    int total = 0;
    int bad = 0;
    int gt3_count, last_fs1, last_fs2, max_x1, max_y1, max_x4, first_fs;
    bit found;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, exp);
        end
    endtask

    task automatic add(input int d, input int c, input int x, input int y, input logic pt,
                       input logic le, input logic fs, input logic gt, input int fc);
        vec_t v;
        v.dut = d; v.cyc = c; v.x = x; v.y = y;
        v.pt = pt; v.le = le; v.fs = fs; v.gt = gt; v.fc = fc;
        tbl.push_back(v);
    endtask

    task automatic check_vec(input vec_t v);
        string t;
        t = $sformatf("u%0d c%0d", v.dut + 1, v.cyc);
        check({t, " x"},  32'(xa[v.dut]),  32'(v.x));
        check({t, " y"},  32'(ya[v.dut]),  32'(v.y));
        check({t, " pt"}, 32'(pta[v.dut]), 32'(v.pt));
        check({t, " le"}, 32'(lea[v.dut]), 32'(v.le));
        check({t, " fs"}, 32'(fsa[v.dut]), 32'(v.fs));
        check({t, " gt"}, 32'(gta[v.dut]), 32'(v.gt));
        check({t, " fc"}, 32'(fca[v.dut]), 32'(v.fc));
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        // u1: DIV=2, 8x4 -> tick on odd cycles, line every 16, frame every 64
        add(0, 0,   0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add(0, 1,   0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(0, 2,   1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add(0, 15,  7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(0, 16,  0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        add(0, 17,  0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(0, 63,  7, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(0, 64,  0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 0);
        add(0, 65,  0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        add(0, 128, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1);
        add(0, 129, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        // u2: DIV=1 -> x advances every cycle, frame every 32
        add(1, 0,   0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(1, 7,   7, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(1, 8,   0, 1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
        add(1, 31,  7, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(1, 32,  0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0);
        add(1, 33,  1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        add(1, 64,  0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1);
        add(1, 65,  1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
        // u3: TICK_FRAMES=3 -> GameTick on frames 3, 6, 9
        add(2, 64,  0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        add(2, 128, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1);
        add(2, 192, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 2);
        add(2, 193, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        add(2, 256, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 3);
        add(2, 384, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 5);
        add(2, 576, 0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 8);
        // u4: default geometry, first line is 1600 cycles
        add(3, 1,    0,   0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(3, 2,    1,   0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        add(3, 1599, 799, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        add(3, 1600, 0,   1, 1'b0, 1'b1, 1'b0, 1'b0, 0);

        rst = 1'b1; rst1 = 1'b1; run1 = 1'b1; run_all = 1'b1;
        repeat (3) step();
        check("reset pt u1", 32'(pta[0]), 32'd0);
        check("reset pt u2", 32'(pta[1]), 32'd0);
        check("reset x u1", 32'(xa[0]), 32'd0);

        gt3_count = 0; last_fs1 = -1; last_fs2 = -1;
        max_x1 = 0; max_y1 = 0; max_x4 = 0;
        @(negedge clk);
        rst = 1'b0; rst1 = 1'b0;
        for (int c = 0; c <= 1700; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            foreach (tbl[i]) if (tbl[i].cyc == c) check_vec(tbl[i]);
            if (int'(xa[0]) > max_x1) max_x1 = int'(xa[0]);
            if (int'(ya[0]) > max_y1) max_y1 = int'(ya[0]);
            if (int'(xa[3]) > max_x4) max_x4 = int'(xa[3]);
            if (c <= 600 && gta[2] === 1'b1) begin
                gt3_count++;
                check($sformatf("u3 gt without fs c%0d", c), 32'(fsa[2]), 32'd1);
            end
            if (fsa[0] === 1'b1) begin
                if (last_fs1 >= 0) check("u1 frame period", 32'(c - last_fs1), 32'd64);
                last_fs1 = c;
            end
            if (fsa[1] === 1'b1) begin
                if (last_fs2 >= 0) check("u2 frame period", 32'(c - last_fs2), 32'd32);
                last_fs2 = c;
            end
        end
        check("u3 gametick count", 32'(gt3_count), 32'd3);
        check("u1 max x", 32'(max_x1), 32'd7);
        check("u1 max y", 32'(max_y1), 32'd3);
        check("u4 max x", 32'(max_x4), 32'd799);

        // Run freeze at (5,2) in the tick cycle: divider must resume at DIV-1
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (xa[0] == 16'd5 && ya[0] == 16'd2 && pta[0] === 1'b1) found = 1'b1;
        end
        check("wait for (5,2)", 32'(found), 32'd1);
        run1 = 1'b0;
        #1;
        check("freeze pt now", 32'(pta[0]), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("freeze x", 32'(xa[0]), 32'd5);
            check("freeze y", 32'(ya[0]), 32'd2);
            check("freeze strobes", {29'd0, pta[0], lea[0], fsa[0]}, 32'd0);
        end
        @(negedge clk);
        run1 = 1'b1;
        #1;
        check("resume pt", 32'(pta[0]), 32'd1);
        check("resume x held", 32'(xa[0]), 32'd5);
        step();
        check("resume x next", 32'(xa[0]), 32'd6);
        check("resume y next", 32'(ya[0]), 32'd2);
        check("resume pt spacing", 32'(pta[0]), 32'd0);
        step();
        check("resume pt again", 32'(pta[0]), 32'd1);

        // Reset pulse at (7,3) just before the frame wrap
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (xa[0] == 16'd7 && ya[0] == 16'd3 && pta[0] === 1'b1) found = 1'b1;
        end
        check("wait for (7,3)", 32'(found), 32'd1);
        rst1 = 1'b1;
        #1;
        check("reset forces pt 0", 32'(pta[0]), 32'd0);
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        check("post reset x", 32'(xa[0]), 32'd0);
        check("post reset y", 32'(ya[0]), 32'd0);
        check("post reset fc", 32'(fca[0]), 32'd0);
        check("post reset strobes", {28'd0, pta[0], lea[0], fsa[0], gta[0]}, 32'd0);
        first_fs = -1;
        for (int c = 1; c <= 100 && first_fs < 0; c++) begin
            step();
            if (fsa[0] === 1'b1) first_fs = c;
        end
        check("first fs after reset", 32'(first_fs), 32'd64);
        check("fc at first fs", 32'(fca[0]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
